// File: rtl/fifo_panel_pkg.sv
// Shared constants for the front-panel FIFO sequencer: FSM state encodings
// and default timing parameters.
package fifo_panel_pkg;

  localparam int TICK_DIV_DEFAULT    = 50000;
  localparam int DEB_SAMPLES_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_ISSUE   = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchronizer, tick-sampled history,
// hysteretic debounced level and a one-clock rising-edge press event.
module key_debounce
  import fifo_panel_pkg::*;
#(
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic key,
  output logic level,
  output logic press
);

  logic                   sync_0;
  logic                   sync_1;
  logic                   level_d;
  logic [DEB_SAMPLES-1:0] history;
  logic [DEB_SAMPLES-1:0] history_next;

  assign history_next = {history[DEB_SAMPLES-2:0], sync_1};

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_0  <= 1'b0;
      sync_1  <= 1'b0;
      history <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync_0  <= key;
      sync_1  <= sync_0;
      level_d <= level;
      // Level is decided on the freshly shifted history so it moves on the qualifying tick.
      if (tick) begin
        history <= history_next;
        if (&history_next) begin
          level <= 1'b1;
        end else if (~|history_next) begin
          level <= 1'b0;
        end
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/fifo_panel_ctrl.sv
// Front-panel sequencer: sample tick divider, two debounced keys, a
// press/issue/hold FSM producing gated FIFO strobes and a shadow level.
module fifo_panel_ctrl
  import fifo_panel_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEFAULT,
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEFAULT,
  parameter int DEPTH       = 128,
  parameter int LVL_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_read,
  input  logic             key_write,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  output logic             fifo_read,
  output logic             fifo_write,
  output logic             reject,
  output logic             busy,
  output logic [LVL_W-1:0] level
);

  localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH - 1);

  logic [CNT_W-1:0] tick_count;
  logic             tick;
  logic [1:0]       keys;
  logic [1:0]       deb_level;
  logic [1:0]       press;
  logic [1:0]       press_d;
  logic [1:0]       state;
  logic             req_r;
  logic             req_w;
  logic             issue;

  assign tick = (tick_count == CNT_TOP);

  always_ff @(posedge clock) begin
    if (reset || tick) begin
      tick_count <= '0;
    end else begin
      tick_count <= tick_count + CNT_W'(1);
    end
  end

  // Index 0 is the read key, index 1 the write key.
  assign keys = {key_write, key_read};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      key_debounce #(
        .DEB_SAMPLES(DEB_SAMPLES)
      ) u_key (
        .clock(clock),
        .reset(reset),
        .tick (tick),
        .key  (keys[gi]),
        .level(deb_level[gi]),
        .press(press[gi])
      );
    end
  endgenerate

  // Strobes are combinational in ISSUE so the FIFO flags are those of that clock.
  assign issue      = (state == ST_ISSUE) && !reset;
  assign fifo_read  = issue && req_r && (req_w || !fifo_empty);
  assign fifo_write = issue && req_w && (req_r || !fifo_full);
  assign reject     = issue && ((req_r && !fifo_read) || (req_w && !fifo_write));
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      req_r   <= 1'b0;
      req_w   <= 1'b0;
      press_d <= '0;
      level   <= '0;
    end else begin
      press_d <= press;
      case (state)
        ST_IDLE: begin
          if (|press) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // A second key landing one clock after the first still counts as a joint press.
          req_r <= press[0] | press_d[0];
          req_w <= press[1] | press_d[1];
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (fifo_write && !req_r && level != LVL_MAX) begin
            level <= level + LVL_W'(1);
          end else if (fifo_read && !req_w && level != '0) begin
            level <= level - LVL_W'(1);
          end
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (~|deb_level) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_panel_ctrl.sv
// Directed bench for fifo_panel_ctrl with TICK_DIV=4, DEB_SAMPLES=3.
module tb_fifo_panel_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_read = 1'b0;
  logic       key_write = 1'b0;
  logic       fifo_empty = 1'b0;
  logic       fifo_full = 1'b0;
  logic       fifo_read;
  logic       fifo_write;
  logic       reject;
  logic       busy;
  logic [7:0] level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int phase = 0;
  int wr_total = 0;
  int rd_total = 0;
  int rej_total = 0;
  int wr_last = -1;
  int rd_last = -1;

  always #5 clock = ~clock;

  fifo_panel_ctrl #(
    .TICK_DIV   (4),
    .DEB_SAMPLES(3),
    .DEPTH      (128),
    .LVL_W      (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_read  (key_read),
    .key_write (key_write),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .fifo_read (fifo_read),
    .fifo_write(fifo_write),
    .reject    (reject),
    .busy      (busy),
    .level     (level)
  );

  // Cycle counter and independent model of the sample-tick phase.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) phase <= 0;
    else phase <= (phase == 3) ? 0 : phase + 1;
  end

  always @(negedge clock) begin
    if (fifo_write) begin
      wr_total <= wr_total + 1;
      wr_last  <= cyc;
    end
    if (fifo_read) begin
      rd_total <= rd_total + 1;
      rd_last  <= cyc;
    end
    if (reject) rej_total <= rej_total + 1;
  end

  task automatic wait_tick(output int tc);
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      if (phase == 3) break;
    end
    tc = cyc;
  endtask

  task automatic wait_ticks(input int n);
    int t;
    repeat (n) wait_tick(t);
  endtask

  task automatic reset_on;
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic reset_off;
    reset = 1'b0;
  endtask

  task automatic press_release(input logic rd, input logic wr,
                               output int drd, output int dwr, output int drej);
    int t, b_rd, b_wr, b_rej;
    b_rd = rd_total; b_wr = wr_total; b_rej = rej_total;
    wait_tick(t);
    key_read = rd; key_write = wr;
    wait_ticks(5);
    key_read = 1'b0; key_write = 1'b0;
    wait_ticks(5);
    drd = rd_total - b_rd; dwr = wr_total - b_wr; drej = rej_total - b_rej;
  endtask

  task automatic test_reset;
    reset_on();
    checks++;
    if ({fifo_read, fifo_write, reject, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got rd/wr/rej/busy=%b expected 0000",
               {fifo_read, fifo_write, reject, busy});
    end
    checks++;
    if (level !== 8'd0) begin
      failures++;
      $display("FAIL reset_level: got %0d expected 0", level);
    end
    reset_off();
    $display("reset: outputs=%b level=%0d", {fifo_read, fifo_write, reject, busy}, level);
  endtask

  task automatic test_bounce_write;
    int t, t5, b_wr, b_rd, b_rej;
    fifo_empty = 1'b1; fifo_full = 1'b0;
    b_wr = wr_total; b_rd = rd_total; b_rej = rej_total;
    wait_tick(t); key_write = 1'b1;
    wait_tick(t); key_write = 1'b0;
    wait_tick(t); key_write = 1'b1;
    wait_tick(t); wait_tick(t); wait_tick(t5);
    checks++;
    if (wr_total - b_wr !== 0) begin
      failures++;
      $display("FAIL bounce_early: got %0d writes before debounce expected 0", wr_total - b_wr);
    end
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (wr_total - b_wr !== 1 || wr_last !== t5 + 3) begin
      failures++;
      $display("FAIL bounce_write: got count=%0d cycle=%0d expected count=1 cycle=%0d",
               wr_total - b_wr, wr_last, t5 + 3);
    end
    checks++;
    if (level !== 8'd1) begin
      failures++;
      $display("FAIL bounce_level: got %0d expected 1", level);
    end
    checks++;
    if (rd_total - b_rd !== 0 || rej_total - b_rej !== 0) begin
      failures++;
      $display("FAIL bounce_other: got reads=%0d rejects=%0d expected 0/0",
               rd_total - b_rd, rej_total - b_rej);
    end
    wait_tick(t); key_write = 1'b0;
    wait_ticks(2);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL bounce_busy_held: got %b expected 1", busy);
    end
    wait_ticks(3);
    checks++;
    if (busy !== 1'b0 || wr_total - b_wr !== 1) begin
      failures++;
      $display("FAIL bounce_release: got busy=%b writes=%0d expected busy=0 writes=1",
               busy, wr_total - b_wr);
    end
    $display("bounce_write: writes=%0d at cycle %0d level=%0d", wr_total - b_wr, wr_last, level);
  endtask

  task automatic test_both_empty;
    int drd, dwr, drej;
    fifo_empty = 1'b1; fifo_full = 1'b0;
    press_release(1'b1, 1'b1, drd, dwr, drej);
    checks++;
    if (drd !== 1 || dwr !== 1 || rd_last !== wr_last) begin
      failures++;
      $display("FAIL both_strobes: got rd=%0d@%0d wr=%0d@%0d expected 1/1 same cycle",
               drd, rd_last, dwr, wr_last);
    end
    checks++;
    if (drej !== 0 || level !== 8'd1) begin
      failures++;
      $display("FAIL both_level: got reject=%0d level=%0d expected 0/1", drej, level);
    end
    $display("both_empty: rd=%0d wr=%0d rej=%0d level=%0d", drd, dwr, drej, level);
  endtask

  task automatic test_read_empty;
    int drd, dwr, drej;
    reset_on(); reset_off();
    fifo_empty = 1'b1; fifo_full = 1'b0;
    press_release(1'b1, 1'b0, drd, dwr, drej);
    checks++;
    if (drd !== 0 || dwr !== 0 || drej !== 1) begin
      failures++;
      $display("FAIL read_empty: got rd=%0d wr=%0d rej=%0d expected 0/0/1", drd, dwr, drej);
    end
    checks++;
    if (level !== 8'd0) begin
      failures++;
      $display("FAIL read_empty_level: got %0d expected 0", level);
    end
    $display("read_empty: rd=%0d rej=%0d level=%0d", drd, drej, level);
  endtask

  task automatic test_hold_ignore;
    int t, b_rd, b_wr, b_rej, drd, dwr, drej;
    fifo_empty = 1'b0; fifo_full = 1'b0;
    b_wr = wr_total;
    wait_tick(t); key_write = 1'b1;
    wait_ticks(5);
    checks++;
    if (wr_total - b_wr !== 1 || level !== 8'd1) begin
      failures++;
      $display("FAIL hold_write: got writes=%0d level=%0d expected 1/1", wr_total - b_wr, level);
    end
    b_rd = rd_total; b_rej = rej_total;
    key_read = 1'b1;
    wait_ticks(5);
    checks++;
    if (rd_total - b_rd !== 0 || rej_total - b_rej !== 0) begin
      failures++;
      $display("FAIL hold_ignore: got reads=%0d rejects=%0d expected 0/0",
               rd_total - b_rd, rej_total - b_rej);
    end
    wait_tick(t); key_read = 1'b0; key_write = 1'b0;
    wait_ticks(6);
    press_release(1'b1, 1'b0, drd, dwr, drej);
    checks++;
    if (drd !== 1 || dwr !== 0 || level !== 8'd0) begin
      failures++;
      $display("FAIL hold_then_read: got rd=%0d wr=%0d level=%0d expected 1/0/0", drd, dwr, level);
    end
    $display("hold_ignore: later read=%0d level=%0d", drd, level);
  endtask

  task automatic test_fill_full;
    int drd, dwr, drej;
    reset_on(); reset_off();
    fifo_empty = 1'b0; fifo_full = 1'b0;
    for (int i = 0; i < 127; i++) press_release(1'b0, 1'b1, drd, dwr, drej);
    checks++;
    if (level !== 8'd127) begin
      failures++;
      $display("FAIL fill_level: got %0d expected 127", level);
    end
    press_release(1'b0, 1'b1, drd, dwr, drej);
    checks++;
    if (dwr !== 1 || level !== 8'd127) begin
      failures++;
      $display("FAIL fill_clamp: got wr=%0d level=%0d expected 1/127", dwr, level);
    end
    fifo_full = 1'b1;
    press_release(1'b0, 1'b1, drd, dwr, drej);
    checks++;
    if (dwr !== 0 || drej !== 1 || level !== 8'd127) begin
      failures++;
      $display("FAIL full_write: got wr=%0d rej=%0d level=%0d expected 0/1/127", dwr, drej, level);
    end
    press_release(1'b1, 1'b0, drd, dwr, drej);
    checks++;
    if (drd !== 1 || drej !== 0 || level !== 8'd126) begin
      failures++;
      $display("FAIL full_read: got rd=%0d rej=%0d level=%0d expected 1/0/126", drd, drej, level);
    end
    fifo_full = 1'b0;
    $display("fill_full: level=%0d", level);
  endtask

  task automatic test_reset_capture;
    int t, t3, b_wr;
    fifo_empty = 1'b0; fifo_full = 1'b0;
    b_wr = wr_total;
    wait_tick(t); key_write = 1'b1;
    wait_ticks(2); wait_tick(t);
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL capture_busy: got %b expected 1", busy);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if ({fifo_read, fifo_write, reject, busy} !== 4'b0000 || level !== 8'd0) begin
      failures++;
      $display("FAIL capture_reset: got rd/wr/rej/busy=%b level=%0d expected 0000/0",
               {fifo_read, fifo_write, reject, busy}, level);
    end
    reset = 1'b0;
    wait_tick(t); wait_tick(t); wait_tick(t3);
    checks++;
    if (wr_total - b_wr !== 0) begin
      failures++;
      $display("FAIL capture_cancel: got %0d writes expected 0", wr_total - b_wr);
    end
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (wr_total - b_wr !== 1 || wr_last !== t3 + 3 || level !== 8'd1) begin
      failures++;
      $display("FAIL capture_repress: got count=%0d cycle=%0d level=%0d expected 1/%0d/1",
               wr_total - b_wr, wr_last, level, t3 + 3);
    end
    key_write = 1'b0;
    wait_ticks(6);
    $display("reset_capture: writes after reset=%0d level=%0d", wr_total - b_wr, level);
  endtask

  initial begin
    test_reset();
    test_bounce_write();
    test_both_empty();
    test_read_empty();
    test_hold_ignore();
    test_fill_full();
    test_reset_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
